// File: rtl/fadd_close_pipe_if.sv
// -----------------------------------------------------------------------------
// fadd_close_pipe_if
// Bundle of the close-path mantissa stage: an input beat (valid/ready plus the
// pre-aligned operands) and an output beat (valid/ready plus the normalised
// result and its flags).
//   master : upstream/downstream environment view (drives operands, out_ready)
//   slave  : the close-path pipeline view (drives in_ready and the result)
// -----------------------------------------------------------------------------
interface fadd_close_pipe_if #(
  parameter int FRAC_WIDTH = 40,
  parameter int EXP_WIDTH  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  exp_a_neq_b;
  logic                  far_sign;
  logic [EXP_WIDTH-1:0]  exp_f;
  logic [FRAC_WIDTH-1:0] elarge_op;
  logic [FRAC_WIDTH-1:0] esmall_op;
  logic                  out_valid;
  logic                  out_ready;
  logic [FRAC_WIDTH-1:0] close_result;
  logic [EXP_WIDTH-1:0]  exp_close;
  logic                  close_sign;
  logic                  close_zero;
  logic                  close_uf;

  modport master (
    output in_valid, exp_a_neq_b, far_sign, exp_f, elarge_op, esmall_op, out_ready,
    input  in_ready, out_valid, close_result, exp_close, close_sign, close_zero, close_uf
  );

  modport slave (
    input  in_valid, exp_a_neq_b, far_sign, exp_f, elarge_op, esmall_op, out_ready,
    output in_ready, out_valid, close_result, exp_close, close_sign, close_zero, close_uf
  );
endinterface

// File: rtl/fadd_close_pipe.sv
// -----------------------------------------------------------------------------
// fadd_close_pipe
// Three-stage close-path mantissa pipeline of the floating-point adder.
// Subtracts two pre-aligned significands (exponents differ by at most one),
// takes the magnitude, normalises it with an exact leading-zero count and
// adjusts the exponent, flagging exact zero and exponent underflow.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : in_valid/in_ready + exp_a_neq_b, far_sign, exp_f, elarge_op,
//                esmall_op in; out_valid/out_ready + close_result, exp_close,
//                close_sign, close_zero, close_uf out (all outputs registered)
// Stage 1: subtract / magnitude. Stage 2: LZC, zero, exponent.
// Stage 3: normalising shift, underflow clamp, output registers.
// -----------------------------------------------------------------------------
module fadd_close_pipe #(
  parameter int FRAC_WIDTH = 40,
  parameter int EXP_WIDTH  = 8
) (
  input logic              clk,
  input logic              rst_n,
  fadd_close_pipe_if.slave bus
);
  localparam int SHW = $clog2(FRAC_WIDTH + 2);
  localparam int EW2 = EXP_WIDTH + 2;

  // Exact leading-zero count over FRAC_WIDTH+1 bits; all-zero input gives FRAC_WIDTH+1.
  function automatic logic [SHW-1:0] lzc_f(input logic [FRAC_WIDTH:0] v);
    logic [SHW-1:0] cnt;
    logic           found;
    cnt   = {SHW{1'b0}};
    found = 1'b0;
    for (int i = FRAC_WIDTH; i >= 0; i--) begin
      found = found | v[i];
      cnt   = cnt + {{(SHW-1){1'b0}}, ~found};
    end
    return cnt;
  endfunction

  // Handshake: each stage advances when the stage after it can take its beat.
  logic v1_r, v2_r, v3_r;
  logic adv1_s, adv2_s, adv3_s;

  assign adv3_s       = bus.out_ready | ~v3_r;
  assign adv2_s       = adv3_s | ~v2_r;
  assign adv1_s       = adv2_s | ~v1_r;
  assign bus.in_ready = adv1_s;
  assign bus.out_valid = v3_r;

  // Valid bits of the three stages; data registers may hold don't-cares when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
    end else begin
      if (adv1_s) v1_r <= bus.in_valid;
      if (adv2_s) v2_r <= v1_r;
      if (adv3_s) v3_r <= v2_r;
    end
  end

  // ---------------- Stage 1: subtract and magnitude ----------------
  logic [FRAC_WIDTH-1:0] s_prime_s;
  logic [FRAC_WIDTH:0]   diff_s, rdiff_s, mag_s;
  logic                  borrow_s;

  // Both differences are formed so the magnitude is a plain select on the borrow.
  always_comb begin
    s_prime_s = bus.esmall_op;
    if (bus.exp_a_neq_b) begin
      s_prime_s = {1'b0, bus.esmall_op[FRAC_WIDTH-1:1]};
    end else begin
      s_prime_s = bus.esmall_op;
    end
    diff_s   = {1'b0, bus.elarge_op} - {1'b0, s_prime_s};
    rdiff_s  = {1'b0, s_prime_s} - {1'b0, bus.elarge_op};
    borrow_s = diff_s[FRAC_WIDTH];
    if (borrow_s) begin
      mag_s = rdiff_s;
    end else begin
      mag_s = diff_s;
    end
  end

  logic                  borrow_r1, far_sign_r1;
  logic [FRAC_WIDTH:0]   mag_r1;
  logic [EXP_WIDTH-1:0]  exp_f_r1;

  // Stage 1 data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_r1   <= 1'b0;
      far_sign_r1 <= 1'b0;
      mag_r1      <= {(FRAC_WIDTH+1){1'b0}};
      exp_f_r1    <= {EXP_WIDTH{1'b0}};
    end else if (adv1_s) begin
      borrow_r1   <= borrow_s;
      far_sign_r1 <= bus.far_sign;
      mag_r1      <= mag_s;
      exp_f_r1    <= bus.exp_f;
    end
  end

  // ---------------- Stage 2: LZC, zero flag, exponent ----------------
  logic [SHW-1:0]        lzc_s;
  logic                  zero_s;
  logic signed [EW2-1:0] exp_e_s;

  // Exponent is exp_f + 1 - n, kept signed two bits wider so underflow is visible.
  always_comb begin
    lzc_s   = lzc_f(mag_r1);
    zero_s  = (mag_r1 == {(FRAC_WIDTH+1){1'b0}});
    exp_e_s = $signed({2'b00, exp_f_r1} + EW2'(1'b1) - EW2'(lzc_s));
  end

  logic [SHW-1:0]        lzc_r2;
  logic                  zero_r2, sign_r2;
  logic signed [EW2-1:0] exp_e_r2;
  logic [FRAC_WIDTH-1:0] mag_lo_r2;

  // Stage 2 data registers; mag's top bit is always 0 so only the low bits travel on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lzc_r2    <= {SHW{1'b0}};
      zero_r2   <= 1'b0;
      sign_r2   <= 1'b0;
      exp_e_r2  <= {EW2{1'b0}};
      mag_lo_r2 <= {FRAC_WIDTH{1'b0}};
    end else if (adv2_s) begin
      lzc_r2    <= lzc_s;
      zero_r2   <= zero_s;
      sign_r2   <= far_sign_r1 ^ borrow_r1;
      exp_e_r2  <= exp_e_s;
      mag_lo_r2 <= mag_r1[FRAC_WIDTH-1:0];
    end
  end

  // ---------------- Stage 3: shift, clamp, outputs ----------------
  logic [FRAC_WIDTH-1:0] res_s;
  logic [EXP_WIDTH-1:0]  expc_s;
  logic                  sign_s, zflag_s, uf_s;

  // (mag << n)[FW:1] equals mag[FW-1:0] << (n-1) because n >= 1 for non-zero mag.
  always_comb begin
    res_s   = {FRAC_WIDTH{1'b0}};
    expc_s  = {EXP_WIDTH{1'b0}};
    sign_s  = 1'b0;
    zflag_s = 1'b0;
    uf_s    = 1'b0;
    if (zero_r2) begin
      zflag_s = 1'b1;
    end else begin
      res_s  = mag_lo_r2 << (lzc_r2 - SHW'(1'b1));
      sign_s = sign_r2;
      if (exp_e_r2 < $signed({EW2{1'b0}})) begin
        uf_s = 1'b1;
      end else begin
        expc_s = exp_e_r2[EXP_WIDTH-1:0];
      end
    end
  end

  logic [FRAC_WIDTH-1:0] close_result_r;
  logic [EXP_WIDTH-1:0]  exp_close_r;
  logic                  close_sign_r, close_zero_r, close_uf_r;

  // Output registers; they hold while a result waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      close_result_r <= {FRAC_WIDTH{1'b0}};
      exp_close_r    <= {EXP_WIDTH{1'b0}};
      close_sign_r   <= 1'b0;
      close_zero_r   <= 1'b0;
      close_uf_r     <= 1'b0;
    end else if (adv3_s) begin
      close_result_r <= res_s;
      exp_close_r    <= expc_s;
      close_sign_r   <= sign_s;
      close_zero_r   <= zflag_s;
      close_uf_r     <= uf_s;
    end
  end

  assign bus.close_result = close_result_r;
  assign bus.exp_close    = exp_close_r;
  assign bus.close_sign   = close_sign_r;
  assign bus.close_zero   = close_zero_r;
  assign bus.close_uf     = close_uf_r;
endmodule

// File: tb/tb_fadd_close_pipe.sv
// -----------------------------------------------------------------------------
// tb_fadd_close_pipe
// Scoreboard bench for fadd_close_pipe (FRAC_WIDTH=40, EXP_WIDTH=8).
// Directed beats carry hand-computed expected results that are queued on
// acceptance; an independent monitor pops and compares on each output
// handshake and checks that stalled outputs hold steady.
// -----------------------------------------------------------------------------
module tb_fadd_close_pipe;
  localparam int FW = 40;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fadd_close_pipe_if #(.FRAC_WIDTH(FW), .EXP_WIDTH(EW)) bus ();

  fadd_close_pipe #(.FRAC_WIDTH(FW), .EXP_WIDTH(EW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [FW-1:0] res;
    logic [EW-1:0] ex;
    logic          sign;
    logic          zero;
    logic          uf;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic [FW-1:0] res, input logic [EW-1:0] ex,
                              input logic s, input logic z, input logic u);
    return {res, ex, s, z, u};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic chk_beat(input string name, input exp_t got, input exp_t req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got res=%h exp=%h s=%b z=%b uf=%b, expected res=%h exp=%h s=%b z=%b uf=%b",
               name, got.res, got.ex, got.sign, got.zero, got.uf,
               req.res, req.ex, req.sign, req.zero, req.uf);
    end
  endtask

  // Present one beat from a falling edge and hold it until accepted (bounded).
  task automatic send(input logic [FW-1:0] el, input logic [FW-1:0] es, input logic neq,
                      input logic [EW-1:0] ef, input logic fs, input exp_t e);
    int waited;
    @(negedge clk);
    bus.elarge_op   = el;
    bus.esmall_op   = es;
    bus.exp_a_neq_b = neq;
    bus.exp_f       = ef;
    bus.far_sign    = fs;
    bus.in_valid    = 1'b1;
    waited = 0;
    #1;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", waited);
      bus.in_valid = 1'b0;
    end else begin
      sb_q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: compare each released beat against the scoreboard head; check hold under stall.
  exp_t held;
  logic held_v = 1'b0;
  initial begin
    exp_t got;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held_v = 1'b0;
      end else if (bus.out_valid) begin
        got = {bus.close_result, bus.exp_close, bus.close_sign, bus.close_zero, bus.close_uf};
        if (held_v) chk_beat("hold_stable", got, held);
        if (bus.out_ready) begin
          held_v = 1'b0;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got res=%h exp=%h, expected no beat", got.res, got.ex);
          end else begin
            e = sb_q.pop_front();
            chk_beat("result", got, e);
          end
        end else begin
          held   = got;
          held_v = 1'b1;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_result"},    64'(bus.close_result), 64'd0);
    chk({tag, "_exp"},       64'(bus.exp_close), 64'd0);
    chk({tag, "_flags"},     64'({bus.close_sign, bus.close_zero, bus.close_uf}), 64'd0);
    chk({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.exp_a_neq_b = 1'b0;
    bus.far_sign    = 1'b0;
    bus.exp_f       = 8'h00;
    bus.elarge_op   = 40'h0;
    bus.esmall_op   = 40'h0;
    rst_n           = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Latency: beat enters stage 1 at its accept edge and is visible after the third edge.
    send(40'h80_0000_0000, 40'h40_0000_0000, 1'b0, 8'h80, 1'b0, mk(40'h80_0000_0000, 8'h7F, 1'b0, 1'b0, 1'b0));
    idle();
    #1 chk("lat_edge_k", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1 chk("lat_edge_k1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1 chk("lat_edge_k2", 64'(bus.out_valid), 64'd1);
    drain("drain_latency");

    // Back-to-back: swap, pre-shift, zero then underflow.
    send(40'h40_0000_0000, 40'h80_0000_0000, 1'b0, 8'h80, 1'b0, mk(40'h80_0000_0000, 8'h7F, 1'b1, 1'b0, 1'b0));
    send(40'h80_0000_0000, 40'h80_0000_0000, 1'b1, 8'h80, 1'b0, mk(40'h80_0000_0000, 8'h7F, 1'b0, 1'b0, 1'b0));
    send(40'h12_3456_789A, 40'h12_3456_789A, 1'b0, 8'h80, 1'b1, mk(40'h0, 8'h00, 1'b0, 1'b1, 1'b0));
    send(40'h00_0000_0001, 40'h00_0000_0000, 1'b0, 8'h01, 1'b0, mk(40'h80_0000_0000, 8'h00, 1'b0, 1'b0, 1'b1));
    idle();
    drain("drain_directed");

    // Backpressure: 6 beats, out_ready low for 5 cycles.
    bus.out_ready = 1'b0;
    send(40'hFF_FFFF_FFFF, 40'h00_0000_0001, 1'b0, 8'h10, 1'b1, mk(40'hFF_FFFF_FFFE, 8'h10, 1'b1, 1'b0, 1'b0));
    send(40'h80_0000_0000, 40'hFF_FFFF_FFFF, 1'b1, 8'h80, 1'b0, mk(40'h80_0000_0000, 8'h59, 1'b0, 1'b0, 1'b0));
    send(40'h00_0000_0003, 40'h00_0000_0005, 1'b0, 8'h40, 1'b0, mk(40'h80_0000_0000, 8'h1A, 1'b1, 1'b0, 1'b0));
    fork
      begin
        send(40'h55_5555_5555, 40'h2A_AAAA_AAAA, 1'b0, 8'h20, 1'b1, mk(40'hAA_AAAA_AAAC, 8'h1E, 1'b1, 1'b0, 1'b0));
        send(40'h00_0001_0000, 40'h00_0000_0000, 1'b1, 8'hFF, 1'b0, mk(40'h80_0000_0000, 8'hE8, 1'b0, 1'b0, 1'b0));
        send(40'h00_0000_0001, 40'h00_0000_0001, 1'b1, 8'h27, 1'b0, mk(40'h80_0000_0000, 8'h00, 1'b0, 1'b0, 1'b0));
        idle();
      end
      begin
        @(negedge clk);
        #1 chk("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        #1 chk("bp_in_ready_held", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with beats in flight: only the post-reset beat may emerge.
    bus.out_ready = 1'b0;
    send(40'h80_0000_0000, 40'h40_0000_0000, 1'b0, 8'h80, 1'b0, mk(40'h80_0000_0000, 8'h7F, 1'b0, 1'b0, 1'b0));
    send(40'hFF_FFFF_FFFF, 40'h00_0000_0001, 1'b0, 8'h10, 1'b1, mk(40'hFF_FFFF_FFFE, 8'h10, 1'b1, 1'b0, 1'b0));
    idle();
    @(negedge clk);
    chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    sb_q.delete();
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(40'h55_5555_5555, 40'h2A_AAAA_AAAA, 1'b0, 8'h20, 1'b1, mk(40'hAA_AAAA_AAAC, 8'h1E, 1'b1, 1'b0, 1'b0));
    idle();
    drain("drain_after_reset");
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
